// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB-stage ALU/load results take priority, and
// MDU results queue in a small FIFO. Also keeps the MDU busy scoreboard and raises the decode hazard.
module wb_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_a3,
  input  logic [DATA_W-1:0] alu_wd,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_a3,
  input  logic [DATA_W-1:0] mdu_wd,
  output logic              mdu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_a3,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  output logic              hazard,
  output logic [31:0]       busy,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fifo_a [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_busy;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd;

  logic              w_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_alu_req;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_d;
  logic [31:0]       w_set_vec;
  logic [31:0]       w_clr_vec;
  logic [31:0]       w_busy_nxt;
  logic              w_iss_viol;
  logic              w_mdu_viol;

  // Ready comes only from the registered count, so a same-edge pop never opens a slot early.
  assign w_ready   = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_accept  = mdu_valid && w_ready;
  assign w_push    = w_accept && (mdu_a3 != '0);
  assign w_alu_req = alu_we && (alu_a3 != '0);
  assign w_pop     = !w_alu_req && (r_count != '0);
  assign w_head_a  = r_fifo_a[r_rd_ptr];
  assign w_head_d  = r_fifo_d[r_rd_ptr];

  assign w_set_vec  = (iss_valid && (iss_a3 != '0)) ? (32'd1 << iss_a3) : 32'd0;
  assign w_clr_vec  = w_pop ? (32'd1 << w_head_a) : 32'd0;
  // A set wins over a clear of the same register; r0 never goes busy.
  assign w_busy_nxt = ((r_busy & ~w_clr_vec) | w_set_vec) & ~32'd1;

  assign w_iss_viol = iss_valid && (iss_a3 != '0) && r_busy[iss_a3] && !w_clr_vec[iss_a3];
  assign w_mdu_viol = w_accept && (mdu_a3 != '0) && !r_busy[mdu_a3];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= mdu_a3;
      r_fifo_d[r_wr_ptr] <= mdu_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_nxt;
      if (w_iss_viol || w_mdu_viol) r_err <= 1'b1;
    end
  end

  // Address and data hold their last values when no write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
    end else if (w_alu_req) begin
      r_we <= 1'b1;
      r_a3 <= alu_a3;
      r_wd <= alu_wd;
    end else if (w_pop) begin
      r_we <= 1'b1;
      r_a3 <= w_head_a;
      r_wd <= w_head_d;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign hazard    = ((chk_a1 != '0) && r_busy[chk_a1]) || ((chk_a2 != '0) && r_busy[chk_a2]);
  assign mdu_ready = w_ready;
  assign busy      = r_busy;
  assign A3        = r_a3;
  assign WD3       = r_wd;
  assign WE3       = r_we;
  assign err       = r_err;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, async-reset sequence,
// then random traffic checked against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_a3 = '0;
  logic [31:0] alu_wd = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_a3 = '0;
  logic [31:0] mdu_wd = '0;
  logic        mdu_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_a3 = '0;
  logic [4:0]  chk_a1 = '0;
  logic [4:0]  chk_a2 = '0;
  logic        hazard;
  logic [31:0] busy;
  logic [4:0]  a3_o;
  logic [31:0] wd3_o;
  logic        we3_o;
  logic        err;

  int total = 0;
  int bad   = 0;

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_we(alu_we), .alu_a3(alu_a3), .alu_wd(alu_wd),
    .mdu_valid(mdu_valid), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .iss_valid(iss_valid), .iss_a3(iss_a3),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard), .busy(busy),
    .A3(a3_o), .WD3(wd3_o), .WE3(we3_o), .err(err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ia,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] c1, input logic [4:0] c2);
    iss_valid = iv; iss_a3 = ia;
    mdu_valid = mv; mdu_a3 = ma; mdu_wd = md;
    alu_we = aw; alu_a3 = aa; alu_wd = ad;
    chk_a1 = c1; chk_a2 = c2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Directed vector table
  typedef struct {
    logic        iv;  logic [4:0] ia;
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic        aw;  logic [4:0] aa; logic [31:0] ad;
    logic [4:0]  c1;  logic [4:0] c2;
    logic        e_rdy; logic e_haz;
    logic        e_we; logic [4:0] e_a3; logic [31:0] e_wd; logic [31:0] e_busy; logic e_err;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mkv(logic iv, logic [4:0] ia, logic mv, logic [4:0] ma, logic [31:0] md,
                               logic aw, logic [4:0] aa, logic [31:0] ad, logic [4:0] c1, logic [4:0] c2,
                               logic rdy, logic haz, logic we, logic [4:0] a3, logic [31:0] wd,
                               logic [31:0] bz, logic er);
    vec_t v;
    v.iv = iv; v.ia = ia; v.mv = mv; v.ma = ma; v.md = md;
    v.aw = aw; v.aa = aa; v.ad = ad; v.c1 = c1; v.c2 = c2;
    v.e_rdy = rdy; v.e_haz = haz; v.e_we = we; v.e_a3 = a3; v.e_wd = wd;
    v.e_busy = bz; v.e_err = er;
    return v;
  endfunction

  // Reference model: MDU results as a FIFO queue, busy as a per-register flag array
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  bit          busy_m [32];
  logic        m_we, m_err, m_ready, m_haz;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_err = 1'b0;
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_pre();
    m_ready = (mq.size() < DEPTH);
    m_haz = (chk_a1 != 0 && busy_m[chk_a1]) || (chk_a2 != 0 && busy_m[chk_a2]);
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge(output bit accepted);
    ent_t e;
    bit   do_clr = 1'b0;
    int   clr = 0;
    accepted = mdu_valid && (mq.size() < DEPTH);
    if (alu_we && alu_a3 != 0) begin
      m_we = 1'b1; m_a3 = alu_a3; m_wd = alu_wd;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_a3 = e.a; m_wd = e.d;
      do_clr = 1'b1; clr = e.a;
    end else begin
      m_we = 1'b0;
    end
    if (iss_valid && iss_a3 != 0 && busy_m[iss_a3] && !(do_clr && clr == iss_a3)) m_err = 1'b1;
    if (accepted && mdu_a3 != 0 && !busy_m[mdu_a3]) m_err = 1'b1;
    if (do_clr) busy_m[clr] = 1'b0;
    if (iss_valid && iss_a3 != 0) busy_m[iss_a3] = 1'b1;
    if (accepted && mdu_a3 != 0) begin
      e.a = mdu_a3; e.d = mdu_wd;
      mq.push_back(e);
    end
  endtask

  initial begin
    int unsigned dl[$];
    bit          cur_valid;
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    bit          acc;
    int          r;
    int          idx;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we3_o, 1'b0);
    chk("rst_a3", a3_o, 5'd0);
    chk("rst_wd", wd3_o, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_ready", mdu_ready, 1'b1);

    tbl[0]  = mkv(1,5, 0,0,0,            0,0,0,        5,0, 1,0, 0,0,0,            32'h20,0);
    tbl[1]  = mkv(0,0, 0,0,0,            0,0,0,        5,0, 1,1, 0,0,0,            32'h20,0);
    tbl[2]  = mkv(0,0, 0,0,0,            0,0,0,        5,0, 1,1, 0,0,0,            32'h20,0);
    tbl[3]  = mkv(0,0, 1,5,32'hDEADBEEF, 0,0,0,        5,0, 1,1, 0,0,0,            32'h20,0);
    tbl[4]  = mkv(0,0, 0,0,0,            0,0,0,        5,0, 1,1, 1,5,32'hDEADBEEF, 32'h0,0);
    tbl[5]  = mkv(0,0, 0,0,0,            0,0,0,        5,0, 1,0, 0,5,32'hDEADBEEF, 32'h0,0);
    tbl[6]  = mkv(1,6, 0,0,0,            0,0,0,        6,7, 1,0, 0,5,32'hDEADBEEF, 32'h40,0);
    tbl[7]  = mkv(1,7, 0,0,0,            0,0,0,        6,7, 1,1, 0,5,32'hDEADBEEF, 32'hC0,0);
    tbl[8]  = mkv(0,0, 1,6,32'h66,       1,1,32'h11,   0,0, 1,0, 1,1,32'h11,       32'hC0,0);
    tbl[9]  = mkv(0,0, 1,7,32'h77,       1,2,32'h22,   0,0, 1,0, 1,2,32'h22,       32'hC0,0);
    tbl[10] = mkv(0,0, 0,0,0,            1,3,32'h33,   0,0, 0,0, 1,3,32'h33,       32'hC0,0);
    tbl[11] = mkv(0,0, 0,0,0,            1,4,32'h44,   0,0, 0,0, 1,4,32'h44,       32'hC0,0);
    tbl[12] = mkv(0,0, 0,0,0,            0,0,0,        0,0, 0,0, 1,6,32'h66,       32'h80,0);
    tbl[13] = mkv(0,0, 0,0,0,            0,0,0,        0,0, 1,0, 1,7,32'h77,       32'h0,0);
    tbl[14] = mkv(0,0, 0,0,0,            0,0,0,        0,0, 1,0, 0,7,32'h77,       32'h0,0);
    tbl[15] = mkv(1,9, 0,0,0,            0,0,0,        0,0, 1,0, 0,7,32'h77,       32'h200,0);
    tbl[16] = mkv(0,0, 1,9,32'h99,       1,0,32'h5A,   9,0, 1,1, 0,7,32'h77,       32'h200,0);
    tbl[17] = mkv(0,0, 0,0,0,            1,0,32'h5A,   9,0, 1,1, 1,9,32'h99,       32'h0,0);
    tbl[18] = mkv(0,0, 1,0,32'h1234,     0,0,0,        0,0, 1,0, 0,9,32'h99,       32'h0,0);
    tbl[19] = mkv(0,0, 0,0,0,            0,0,0,        0,0, 1,0, 0,9,32'h99,       32'h0,0);
    tbl[20] = mkv(1,8, 0,0,0,            0,0,0,        8,0, 1,0, 0,9,32'h99,       32'h100,0);
    tbl[21] = mkv(0,0, 1,8,32'h88,       0,0,0,        8,0, 1,1, 0,9,32'h99,       32'h100,0);
    tbl[22] = mkv(1,8, 0,0,0,            0,0,0,        8,0, 1,1, 1,8,32'h88,       32'h100,0);
    tbl[23] = mkv(0,0, 1,12,32'hCC,      0,0,0,        0,0, 1,0, 0,8,32'h88,       32'h100,1);
    tbl[24] = mkv(0,0, 0,0,0,            0,0,0,        0,0, 1,0, 1,12,32'hCC,      32'h100,1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].mv, tbl[i].ma, tbl[i].md,
            tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].c1, tbl[i].c2);
      #1;
      chk($sformatf("v%0d_ready", i), mdu_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_hazard", i), hazard, tbl[i].e_haz);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), we3_o, tbl[i].e_we);
      chk($sformatf("v%0d_a3", i), a3_o, tbl[i].e_a3);
      chk($sformatf("v%0d_wd", i), wd3_o, tbl[i].e_wd);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
    end

    // Async reset in the middle of a cycle with a full FIFO, busy r4 and err set
    do_reset();
    drive(1'b1, 5'd4, 1'b1, 5'd12, 32'hC12, 1'b1, 5'd1, 32'hA1, 5'd0, 5'd0);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 1'b1, 5'd4, 32'hD4, 1'b1, 5'd1, 32'hA2, 5'd0, 5'd0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("full_ready", mdu_ready, 1'b0);
    chk("full_busy", busy, 32'h10);
    chk("full_err", err, 1'b1);
    chk("full_we", we3_o, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", we3_o, 1'b0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_err", err, 1'b0);
    chk("arst_a3", a3_o, 5'd0);
    chk("arst_wd", wd3_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("arst_ready", mdu_ready, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("arst_drained_we", we3_o, 1'b0);
      chk("arst_drained_busy", busy, 32'd0);
    end

    // Random traffic against the reference model
    do_reset();
    model_reset();
    cur_valid = 1'b0; cur_a = '0; cur_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      alu_we = ($urandom_range(0, 99) < 45);
      alu_a3 = 5'($urandom_range(0, 31));
      alu_wd = $urandom;
      if (!cur_valid) begin
        if (dl.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx = $urandom_range(0, dl.size() - 1);
          cur_a = 5'(dl[idx]);
          dl.delete(idx);
          cur_d = $urandom;
          cur_valid = 1'b1;
        end else if ($urandom_range(0, 19) == 0) begin
          cur_a = '0;
          cur_d = $urandom;
          cur_valid = 1'b1;
        end
      end
      mdu_valid = cur_valid; mdu_a3 = cur_a; mdu_wd = cur_d;
      r = $urandom_range(0, 31);
      iss_valid = ($urandom_range(0, 2) == 0) && !busy_m[r];
      iss_a3 = 5'(r);
      chk_a1 = 5'($urandom_range(0, 31));
      chk_a2 = 5'($urandom_range(0, 31));
      #1;
      model_pre();
      chk("rnd_ready", mdu_ready, m_ready);
      chk("rnd_hazard", hazard, m_haz);
      model_edge(acc);
      @(posedge clk); #1;
      chk("rnd_we", we3_o, m_we);
      chk("rnd_a3", a3_o, m_a3);
      chk("rnd_wd", wd3_o, m_wd);
      chk("rnd_busy", busy, busy_vec());
      chk("rnd_err", err, m_err);
      if (acc) cur_valid = 1'b0;
      if (iss_valid && r != 0) dl.push_back(r);
    end
    idle();

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
